// File: rtl/expr_pkg.sv
// expr_pkg: shared state encodings and character constants for the expression scheduler
package expr_pkg;
  typedef enum logic [1:0] {ARB, FEED, DONE} sched_t;
  typedef enum logic [1:0] {IDLE, NUM, OP, ERR} chk_t;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
endpackage

// File: rtl/expr_fsm.sv
// expr_fsm: single-digit infix expression checker, one byte per enabled cycle
module expr_fsm
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] char,
  output chk_t       state
);
  chk_t r_state, w_next;
  logic w_digit, w_op;
  assign w_digit = (char >= CH_0) && (char <= CH_9);
  assign w_op    = (char == CH_PLUS) || (char == CH_STAR);
  always_comb begin
    w_next = r_state;
    if (clear)
      w_next = IDLE;
    else if (en)
      w_next = ((r_state == IDLE || r_state == OP) && w_digit) ? NUM :
               (r_state == NUM && w_op)                          ? OP  : ERR;
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) r_state <= IDLE;
    else      r_state <= w_next;
  assign state = r_state;
endmodule

// File: rtl/expr_sched.sv
// expr_sched: round-robin owner of one shared expression checker across N_REQ byte streams
module expr_sched
  import expr_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int MAX_LEN = 32,
  localparam int LW      = $clog2(MAX_LEN + 1),
  localparam int IW      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_char,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               res_valid,
  output logic               res_ok,
  output logic [IW-1:0]      res_id,
  output logic [LW-1:0]      res_len,
  output logic               busy
);
  sched_t           r_state, w_next;
  logic [IW-1:0]    r_ptr, r_owner, r_id, w_win;
  logic [N_REQ-1:0] r_grant;
  logic [LW-1:0]    r_len, r_rlen;
  logic             r_ovf, r_ok, w_any, w_hs, w_feed, w_ok;
  logic [7:0]       w_char;
  chk_t             w_chk;
  // Scan from r_ptr; the lowest offset with a valid request wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_ptr) + k) % N_REQ);
      end
  end
  assign w_char = req_char[{r_owner, 3'b000} +: 8];
  assign w_hs   = (r_state == FEED) && req_valid[r_owner];
  assign w_feed = w_hs && (r_len != LW'(MAX_LEN));
  assign w_ok   = (w_chk == NUM) && !r_ovf;
  always_comb begin
    w_next = r_state;
    if (r_state == ARB)
      w_next = w_any ? FEED : ARB;
    else if (r_state == FEED)
      w_next = (w_hs && req_last[r_owner]) ? DONE : FEED;
    else
      w_next = ARB;
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_ok    <= 1'b0;
      r_id    <= '0;
      r_rlen  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ARB) begin
        r_len <= '0;
        r_ovf <= 1'b0;
        if (w_any) begin
          r_grant <= N_REQ'(1) << w_win;
          r_owner <= w_win;
          r_ptr   <= (w_win == IW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
        end
      end else if (r_state == FEED) begin
        if (w_feed)
          r_len <= r_len + 1'b1;
        else if (w_hs)
          r_ovf <= 1'b1;
      end else begin
        r_grant <= '0;
        r_ok    <= w_ok;
        r_id    <= r_owner;
        r_rlen  <= r_len;
      end
    end
  expr_fsm u_chk (
    .clk  (clk),
    .clr  (clr),
    .clear(r_state == ARB),
    .en   (w_feed),
    .char (w_char),
    .state(w_chk)
  );
  // Verdict is live during DONE and held from the capture registers afterwards.
  assign res_valid = (r_state == DONE);
  assign res_ok    = res_valid ? w_ok : r_ok;
  assign res_id    = res_valid ? r_owner : r_id;
  assign res_len   = res_valid ? r_len : r_rlen;
  assign grant     = r_grant;
  assign req_ready = (r_state == FEED) ? r_grant : '0;
  assign busy      = (r_state != ARB);
endmodule
